bp_be_fe_queue_ckpt: RTL and testbench
======================================

// Module: bp_be_fe_queue_ckpt
// PURPOSE
//  Checkpointing FIFO between the FE and the BE checker; holds fetched fe_queue packets.
//  Three pointers: write (wptr), speculative read (rptr), committed (cptr).
//  BE reads speculatively with yumi, retires with deq, replays with roll and discards unread entries with clr.
//  Entries stay resident from enqueue until deq, so a roll after an exception or redirect replays them without refetch.
// PARAMETERS
//  width_p  160  packet width in bits (fe_queue_width_lp of the active config)
//  els_p    8    entry count; power of 2, >=2
//  ptr_w    $clog2(els_p)+1 (localparam); pointers carry one extra wrap bit
// PORTS
//  clk_i        in   1        clock, all state updates on rising edge
//  reset_n_i    in   1        asynchronous active-low reset
//  fe_queue_i   in   width_p  packet from FE
//  fe_queue_v_i in   1        FE packet valid
//  fe_queue_ready_o out 1     queue can accept a packet
//  fe_queue_o   out  width_p  packet at rptr
//  fe_queue_v_o out  1        fe_queue_o holds an unread packet
//  fe_queue_yumi_i in 1       BE consumes fe_queue_o this cycle
//  fe_queue_deq_i  in 1       retire oldest read-but-uncommitted entry
//  fe_queue_roll_i in 1       rewind rptr to cptr (replay)
//  fe_queue_clr_i  in 1       discard all unread entries
//  occupancy_o  out  ptr_w    wptr-cptr (resident entries)
// BEHAVIOUR
//  Reset (async, reset_n_i=0): wptr=rptr=cptr=0; fe_queue_v_o=0; fe_queue_ready_o=0; occupancy_o=0.
//   ready_o rises the first cycle after reset deasserts. Storage is not reset.
//  full  = (wptr-cptr)==els_p (MSBs differ, low bits equal); empty = rptr==wptr.
//  fe_queue_ready_o = !full. Enqueue fires on fe_queue_v_i & ready_o & !clr_i:
//   mem[wptr]<=fe_queue_i, wptr+1. Enqueue in a clr cycle is dropped.
//  fe_queue_v_o = !empty; fe_queue_o = mem[rptr[ptr_w-2:0]]. Don't-care when v_o=0.
//  Latency: an enqueued packet appears at fe_queue_o in the next cycle.
//  yumi_i: legal only when v_o=1 → rptr+1. Ignored when roll_i=1.
//  deq_i: legal only when cptr!=rptr → cptr+1. It frees a slot; ready_o reflects this the next cycle.
//  roll_i: rptr <= cptr_next, where cptr_next includes a same-cycle deq.
//  clr_i: wptr <= rptr_next, where rptr_next already includes yumi/roll.
//  clr_i & roll_i together: wptr=rptr=cptr_next, a full flush.
//  Pointer update order per cycle: cptr, then rptr, then wptr.
//  Pointers wrap modulo 2*els_p through natural ptr_w-bit overflow. No saturation logic.
//  Simultaneous enqueue + yumi + deq on a full queue: enqueue is blocked because ready_o was 0.
//  Illegal-use assertions (simulation only): yumi with v_o=0; deq with cptr==rptr; enq when full.
//  Assertions are disabled while reset_n_i=0.
//  Reset asserted mid-operation: all pointers clear immediately and in-flight packets are lost.
// CONFIGURATION
//  BP_FE_QUEUE_BYPASS_EN defined:
//   When empty & fe_queue_v_i & ready_o & !clr_i: v_o=1 and fe_queue_o=fe_queue_i combinationally.
//   yumi in that cycle writes the entry and advances wptr and rptr together (0-cycle latency).
//   Bypass is inhibited when roll_i=1.
//  Undefined: no combinational path from fe_queue_i/v_i to outputs; minimum latency is 1 cycle.
// TESTING
//  1 Reset release, enq A,B,C on consecutive cycles, yumi each once valid
//    -> outputs A,B,C in order; occupancy_o=3; v_o=0 after the third yumi.
//  2 Fill 8 entries, no deq -> ready_o=0 at occupancy 8. yumi all 8: ready_o stays 0.
//    One deq -> ready_o=1 the next cycle.
//  3 Enq P0..P3, yumi P0..P2, deq P0, then roll
//    -> next fe_queue_o=P1, occupancy_o=3, P1..P3 replayed in order.
//  4 Enq P0..P4, yumi P0,P1, then clr with fe_queue_v_i=1 (P5)
//    -> P5 dropped; v_o=0; occupancy_o=2; subsequent enq Q0 is read next.
//  5 Run 40 enq/yumi/deq triples at full rate -> pointer wrap is seamless and data order is preserved.
//    Random reset_n_i pulses mid-stream -> v_o=0 and occupancy_o=0 immediately.
//  6 (BP_FE_QUEUE_BYPASS_EN) Empty queue, enq X with yumi the same cycle
//    -> fe_queue_o=X that cycle; a later roll replays X.
//    Without the macro, v_o=0 in that cycle.

Source files
------------

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing FE->BE packet queue: speculative read pointer, committed pointer, replay and clear.
// Optional same-cycle bypass from fe_queue_i to fe_queue_o when BP_FE_QUEUE_BYPASS_EN is defined.
module bp_be_fe_queue_ckpt #(
    parameter int width_p = 160,
    parameter int els_p   = 8,
    localparam int ptr_w  = $clog2(els_p) + 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    input  logic               fe_queue_clr_i,
    output logic [ptr_w-1:0]   occupancy_o
);

    localparam int idx_w = ptr_w - 1;

    logic [width_p-1:0] mem [els_p];

    logic [ptr_w-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_w-1:0] wptr_n, rptr_n, cptr_n;
    logic             live_r;
    logic             full, empty, enq, bypass;

    // Handshake: a packet is accepted when fe_queue_v_i & fe_queue_ready_o & !fe_queue_clr_i;
    // fe_queue_yumi_i is a consume strobe that may only be raised while fe_queue_v_o is high.
    assign full  = (wptr_r[ptr_w-1] != cptr_r[ptr_w-1])
                && (wptr_r[idx_w-1:0] == cptr_r[idx_w-1:0]);
    assign empty = (rptr_r == wptr_r);

    assign fe_queue_ready_o = live_r & ~full;
    assign enq              = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;

`ifdef BP_FE_QUEUE_BYPASS_EN
    assign bypass = empty & enq & ~fe_queue_roll_i;
`else
    assign bypass = 1'b0;
`endif

    assign fe_queue_v_o = ~empty | bypass;
    assign fe_queue_o   = bypass ? fe_queue_i : mem[rptr_r[idx_w-1:0]];
    assign occupancy_o  = wptr_r - cptr_r;

    // Commit first, then read (roll rewinds to the post-deq commit point), then write
    // (clear truncates to the post-yumi/roll read point).
    always_comb begin
        cptr_n = cptr_r + {{(ptr_w-1){1'b0}}, fe_queue_deq_i};
        rptr_n = fe_queue_roll_i ? cptr_n
                                 : rptr_r + {{(ptr_w-1){1'b0}}, fe_queue_yumi_i};
        wptr_n = fe_queue_clr_i ? rptr_n
                                : wptr_r + {{(ptr_w-1){1'b0}}, enq};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
            live_r <= 1'b0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
            live_r <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; validity is carried entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr_r[idx_w-1:0]] <= fe_queue_i;
        end
    end

`ifndef SYNTHESIS
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fe_queue_yumi_i |-> fe_queue_v_o);
    a_deq_needs_read: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        fe_queue_deq_i |-> (cptr_r != rptr_r));
    a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        enq |-> !full);
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Directed bench for bp_be_fe_queue_ckpt: ordering, full/deq, roll, clr, wrap with reset pulses, bypass.
// Inputs are driven just after the falling edge; outputs are sampled 1 time unit later.
module tb_bp_be_fe_queue_ckpt;

    localparam int W  = 160;
    localparam int PW = 4;

    logic          clk;
    logic          reset_n_i;
    logic [W-1:0]  d;
    logic          v_i, yumi, deq, roll, clr;
    logic          ready;
    logic [W-1:0]  q;
    logic          v_o;
    logic [PW-1:0] occ;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    bp_be_fe_queue_ckpt #(.width_p(W), .els_p(8)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n_i),
        .fe_queue_i      (d),
        .fe_queue_v_i    (v_i),
        .fe_queue_ready_o(ready),
        .fe_queue_o      (q),
        .fe_queue_v_o    (v_o),
        .fe_queue_yumi_i (yumi),
        .fe_queue_deq_i  (deq),
        .fe_queue_roll_i (roll),
        .fe_queue_clr_i  (clr),
        .occupancy_o     (occ)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pkt(input int unsigned n);
        logic [31:0] m;
        m = n;
        return {m, ~m, m ^ 32'hA5A5_5A5A, m + 32'd7, 16'hBEEF, m[15:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        v_i  = 1'b0;
        yumi = 1'b0;
        deq  = 1'b0;
        roll = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n_i = 1'b0;
        @(negedge clk);
        reset_n_i = 1'b1;
        cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (occ !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occ); end
        @(negedge clk);
        reset_n_i = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL release_ready_early got=%b exp=0", ready); end
        cycle();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", ready); end
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL release_v_o got=%b exp=0", v_o); end
    endtask

    task automatic test_order();
        do_reset();
        v_i = 1'b1; d = pkt(1);
        cycle();
        d = pkt(2); yumi = 1'b1;
        #1;
        checks++; if (v_o !== 1'b1) begin failures++; $display("FAIL order_v_o got=%b exp=1", v_o); end
        checks++; if (q !== pkt(1)) begin failures++; $display("FAIL order_a got=%h exp=%h", q, pkt(1)); end
        cycle();
        d = pkt(3);
        #1;
        checks++; if (q !== pkt(2)) begin failures++; $display("FAIL order_b got=%h exp=%h", q, pkt(2)); end
        cycle();
        v_i = 1'b0;
        #1;
        checks++; if (q !== pkt(3)) begin failures++; $display("FAIL order_c got=%h exp=%h", q, pkt(3)); end
        cycle();
        yumi = 1'b0;
        #1;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL order_drained got=%b exp=0", v_o); end
        checks++; if (occ !== 4'd3) begin failures++; $display("FAIL order_occ got=%0d exp=3", occ); end
    endtask

    task automatic test_full();
        do_reset();
        v_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = pkt(100 + i);
            #1;
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, ready); end
            cycle();
        end
        v_i = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ready); end
        checks++; if (occ !== 4'd8) begin failures++; $display("FAIL full_occ got=%0d exp=8", occ); end
        for (int i = 0; i < 8; i++) begin
            yumi = 1'b1;
            #1;
            checks++; if (q !== pkt(100 + i)) begin failures++; $display("FAIL full_read[%0d] got=%h exp=%h", i, q, pkt(100 + i)); end
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_read_ready[%0d] got=%b exp=0", i, ready); end
            cycle();
        end
        yumi = 1'b0;
        #1;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL full_all_read_v_o got=%b exp=0", v_o); end
        deq = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL deq_same_cycle_ready got=%b exp=0", ready); end
        cycle();
        deq = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL deq_next_ready got=%b exp=1", ready); end
        checks++; if (occ !== 4'd7) begin failures++; $display("FAIL deq_occ got=%0d exp=7", occ); end
        v_i = 1'b1; d = pkt(108);
        cycle();
        v_i = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL refull_ready got=%b exp=0", ready); end
        checks++; if (q !== pkt(108)) begin failures++; $display("FAIL refull_q got=%h exp=%h", q, pkt(108)); end
        // enqueue + yumi + deq on a full queue: the enqueue must be blocked
        v_i = 1'b1; d = pkt(109); yumi = 1'b1; deq = 1'b1;
        cycle();
        idle();
        #1;
        checks++; if (occ !== 4'd7) begin failures++; $display("FAIL blocked_enq_occ got=%0d exp=7", occ); end
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL blocked_enq_v_o got=%b exp=0", v_o); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL blocked_enq_ready got=%b exp=1", ready); end
    endtask

    task automatic test_roll();
        do_reset();
        v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = pkt(200 + i);
            cycle();
        end
        v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            yumi = 1'b1;
            #1;
            checks++; if (q !== pkt(200 + i)) begin failures++; $display("FAIL roll_first[%0d] got=%h exp=%h", i, q, pkt(200 + i)); end
            cycle();
        end
        yumi = 1'b0; deq = 1'b1;
        cycle();
        deq = 1'b0; roll = 1'b1;
        cycle();
        roll = 1'b0;
        #1;
        checks++; if (v_o !== 1'b1) begin failures++; $display("FAIL roll_v_o got=%b exp=1", v_o); end
        checks++; if (occ !== 4'd3) begin failures++; $display("FAIL roll_occ got=%0d exp=3", occ); end
        for (int i = 1; i < 4; i++) begin
            yumi = 1'b1;
            #1;
            checks++; if (q !== pkt(200 + i)) begin failures++; $display("FAIL roll_replay[%0d] got=%h exp=%h", i, q, pkt(200 + i)); end
            cycle();
        end
        yumi = 1'b0;
        #1;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL roll_drained got=%b exp=0", v_o); end
        // roll in the same cycle as deq rewinds to the post-deq commit point
        deq = 1'b1; roll = 1'b1;
        cycle();
        idle();
        #1;
        checks++; if (q !== pkt(202)) begin failures++; $display("FAIL roll_deq_q got=%h exp=%h", q, pkt(202)); end
        checks++; if (occ !== 4'd2) begin failures++; $display("FAIL roll_deq_occ got=%0d exp=2", occ); end
    endtask

    task automatic test_clr();
        do_reset();
        v_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = pkt(300 + i);
            cycle();
        end
        v_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            yumi = 1'b1;
            #1;
            checks++; if (q !== pkt(300 + i)) begin failures++; $display("FAIL clr_read[%0d] got=%h exp=%h", i, q, pkt(300 + i)); end
            cycle();
        end
        yumi = 1'b0; clr = 1'b1; v_i = 1'b1; d = pkt(305);
        cycle();
        idle();
        #1;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL clr_v_o got=%b exp=0", v_o); end
        checks++; if (occ !== 4'd2) begin failures++; $display("FAIL clr_occ got=%0d exp=2", occ); end
        v_i = 1'b1; d = pkt(310);
        cycle();
        v_i = 1'b0;
        #1;
        checks++; if (q !== pkt(310)) begin failures++; $display("FAIL clr_next_q got=%h exp=%h", q, pkt(310)); end
        checks++; if (occ !== 4'd3) begin failures++; $display("FAIL clr_next_occ got=%0d exp=3", occ); end
        yumi = 1'b1;
        cycle();
        yumi = 1'b0; deq = 1'b1; clr = 1'b1; roll = 1'b1;
        cycle();
        idle();
        #1;
        checks++; if (occ !== 4'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occ); end
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL flush_v_o got=%b exp=0", v_o); end
    endtask

    task automatic test_wrap_reset();
        int unsigned p1, p2, seq, since;
        logic [W-1:0] exp;
        p1 = $urandom_range(10, 18);
        p2 = $urandom_range(25, 35);
        seq = 0;
        since = 0;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            if (i == p1 || i == p2) begin
                idle();
                reset_n_i = 1'b0;
                #1;
                checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL midreset_v_o[%0d] got=%b exp=0", i, v_o); end
                checks++; if (occ !== 4'd0) begin failures++; $display("FAIL midreset_occ[%0d] got=%0d exp=0", i, occ); end
                #1;
                reset_n_i = 1'b1;
                cycle();
                exp_q.delete();
                since = 0;
            end
            v_i  = 1'b1;
            d    = pkt(1000 + seq);
            yumi = (since >= 1);
            deq  = (since >= 2);
            #1;
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL wrap_ready[%0d] got=%b exp=1", i, ready); end
            if (yumi) begin
                exp = exp_q.pop_front();
                checks++; if (q !== exp) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, q, exp); end
            end
            if (since >= 2) begin
                checks++; if (occ !== 4'd2) begin failures++; $display("FAIL wrap_occ[%0d] got=%0d exp=2", i, occ); end
            end
            exp_q.push_back(pkt(1000 + seq));
            seq++;
            since++;
            cycle();
        end
        idle();
    endtask

    task automatic test_bypass();
        do_reset();
        v_i = 1'b1; d = pkt(500);
`ifdef BP_FE_QUEUE_BYPASS_EN
        yumi = 1'b1;
        #1;
        checks++; if (v_o !== 1'b1) begin failures++; $display("FAIL bypass_v_o got=%b exp=1", v_o); end
        checks++; if (q !== pkt(500)) begin failures++; $display("FAIL bypass_q got=%h exp=%h", q, pkt(500)); end
        cycle();
        idle();
        #1;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL bypass_after_v_o got=%b exp=0", v_o); end
        checks++; if (occ !== 4'd1) begin failures++; $display("FAIL bypass_occ got=%0d exp=1", occ); end
        roll = 1'b1;
        cycle();
        roll = 1'b0;
        #1;
        checks++; if (v_o !== 1'b1) begin failures++; $display("FAIL bypass_roll_v_o got=%b exp=1", v_o); end
        checks++; if (q !== pkt(500)) begin failures++; $display("FAIL bypass_roll_q got=%h exp=%h", q, pkt(500)); end
`else
        #1;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL nobypass_v_o got=%b exp=0", v_o); end
        cycle();
        idle();
        #1;
        checks++; if (v_o !== 1'b1) begin failures++; $display("FAIL nobypass_next_v_o got=%b exp=1", v_o); end
        checks++; if (q !== pkt(500)) begin failures++; $display("FAIL nobypass_q got=%h exp=%h", q, pkt(500)); end
        checks++; if (occ !== 4'd1) begin failures++; $display("FAIL nobypass_occ got=%0d exp=1", occ); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n_i = 1'b0;
        d = '0;
        idle();
        test_reset();
        test_order();
        test_full();
        test_roll();
        test_clr();
        test_wrap_reset();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
